gs_mem_arbiter: RTL and testbench
=================================

Name: gs_mem_arbiter

Overview:
- Shares one external 8-bit SRAM between two requesters: the General Sound Z80 memory port and the ROM/sample loader.
- The GS port is level-strobed: RD/WR are held for many cycles and the block answers with WAIT.
- The loader port is pulse-strobed, one write per pulse.
- Sits between the gs core's MEM_* bus and the board SRAM controller pins, in the single CLK domain.

Parameters:
- ACC_CYCLES, 2: cycles the SRAM strobe is held per access. Read data is sampled on the last of them. Legal range 1..15.
- ROM_PROTECT, 1: when 1, GS writes to GS_ADDR[20:15]==0 (ROM pages) complete normally but do not assert SRAM_WE.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- GS_ADDR  in  21  GS byte address.
- GS_DI  in  8  GS write data.
- GS_DO  out  8  GS read data; holds last completed read.
- GS_RD  in  1  GS read strobe, level.
- GS_WR  in  1  GS write strobe, level.
- GS_WAIT  out  1  high while the current GS strobe is not yet serviced.
- LD_ADDR  in  21  loader address.
- LD_DI  in  8  loader data.
- LD_WR  in  1  one-cycle loader write request.
- LD_BUSY  out  1  loader request pending or in progress.
- SRAM_ADDR  out  21  registered SRAM address.
- SRAM_DQ_O  out  8  registered SRAM write data.
- SRAM_DQ_I  in  8  SRAM read data.
- SRAM_OE  out  1  registered read strobe.
- SRAM_WE  out  1  registered write strobe.

Behaviour:
Reset values:
- RESET (synchronous, active-high) forces state IDLE.
- SRAM_OE=0, SRAM_WE=0, SRAM_ADDR=0, SRAM_DQ_O=0, GS_DO=0.
- LD_BUSY=0, loader pending slot cleared, gs_done=0, last_grant=GS.
- A reset mid-access aborts it; the SRAM strobes are low in the cycle after the reset edge.

GS request and WAIT:
- gs_req = (GS_RD|GS_WR) & ~gs_done.
- GS_WAIT = gs_req, combinational from the strobes and the registered gs_done. It must be high in the same cycle the strobe rises.
- GS_RD and GS_WR together is illegal; RD takes precedence.

gs_done:
- Set on the completing edge of a GS access.
- At that edge the block latches gs_addr_l, gs_rd_l and a 1-bit strobe-type copy.
- Cleared on any edge where both strobes are low, GS_ADDR differs from gs_addr_l, or the strobe type differs.
- Result: exactly one SRAM access per GS strobe episode.

Loader slot:
- An LD_WR pulse while LD_BUSY=0 latches LD_ADDR/LD_DI into the slot; LD_BUSY=1 from the next cycle.
- An LD_WR pulse while LD_BUSY=1 is dropped.
- LD_BUSY falls on the completing edge of the loader access.

FSM states: IDLE, ACCESS.
- In IDLE with requests pending, grant by round-robin against last_grant:
  - both pending → the one not granted last;
  - a single pending requester wins immediately.
- Grant edge (cycle n):
  - drive SRAM_ADDR, SRAM_DQ_O, SRAM_OE (GS read) or SRAM_WE (write, subject to ROM_PROTECT);
  - load cnt=ACC_CYCLES-1; go to ACCESS; record owner.
- ACCESS: cnt decrements each edge. On the edge where cnt==0 (edge n+ACC_CYCLES):
  - owner GS and read → GS_DO<=SRAM_DQ_I;
  - owner GS → gs_done<=1;
  - owner loader → slot cleared;
  - strobes cleared; state → IDLE; last_grant <= owner.
- Earliest new grant is the following edge, so every access is followed by at least one idle strobe cycle (turnaround).
- GS read latency: GS_WAIT high for exactly ACC_CYCLES cycles when uncontended, and GS_DO valid when GS_WAIT falls.
- Worst case with a loader pending: 2*ACC_CYCLES+1 cycles.

Boundary rules:
- GS_ADDR changes during ACCESS: the in-flight access completes with the latched address. gs_done then clears on the next edge because of the mismatch, and a new access is issued.
- GS strobe drops during ACCESS: the access still completes and GS_DO still updates. gs_done is set, then clears the next edge.
- GS write to a protected page: normal timing, SRAM_WE stays 0.

Decomposition:
- Package gs_mem_pkg holds:
  - state enum {IDLE, ACCESS};
  - owner enum {OWN_GS, OWN_LD};
  - constant ADDR_W=21 and the cnt width derived from ACC_CYCLES.
- The loader slot (latch, busy, drop rule) is a natural sub-module, gs_ld_slot. Everything else stays in gs_mem_arbiter.

Test Plan:
1. ACC_CYCLES=2; GS_RD at 0x08123 held 6 cycles, SRAM returns 0x5A → GS_WAIT high 2 cycles, one SRAM_OE pulse 2 cycles wide, GS_DO=0x5A, no second OE while RD stays high.
2. GS_WR 0x00100 data 0x33 with ROM_PROTECT=1 → WAIT 2 cycles, SRAM_WE never asserted. Repeat at 0x08100 → SRAM_WE pulses with SRAM_DQ_O=0x33.
3. LD_WR pulses 0x00000/0x11 and 0x00001/0x22 with the second arriving while busy → only 0x11 written, LD_BUSY high 3 cycles.
4. GS_RD and LD_WR same cycle, last_grant=GS → loader access first, then GS. GS_WAIT high 5 cycles; SRAM strobes separated by one idle cycle.
5. Back-to-back GS reads 0x08000 then 0x08001 with no strobe gap (address change only) → two distinct OE accesses, GS_DO updates twice.
6. RESET asserted mid-ACCESS during a loader write → SRAM_WE low next cycle, LD_BUSY=0, GS_DO=0, the next GS_RD is serviced normally.

Source files
------------

// File: rtl/gs_mem_pkg.sv
// gs_mem_pkg: shared types and sizing for the GS memory arbiter
package gs_mem_pkg;
    localparam int ADDR_W = 21;

    typedef enum logic {IDLE, ACCESS} state_e;
    typedef enum logic {OWN_GS, OWN_LD} owner_e;

    function automatic int cnt_w(input int acc);
        return (acc > 2) ? $clog2(acc) : 1;
    endfunction
endpackage

// File: rtl/gs_ld_slot.sv
// gs_ld_slot: single-entry loader write slot; pulses arriving while busy are dropped
module gs_ld_slot
    import gs_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        data_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        data_o
);
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            busy_q <= 1'b0;
        end else if (wr_i && !busy_q) begin
            busy_q <= 1'b1;
            addr_q <= addr_i;
            data_q <= data_i;
        end
    end

    assign busy_o = busy_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
endmodule

// File: rtl/gs_mem_arbiter.sv
// gs_mem_arbiter: shares one 8-bit SRAM between the GS Z80 port and the ROM/sample loader
module gs_mem_arbiter
    import gs_mem_pkg::*;
#(
    parameter int ACC_CYCLES  = 2,
    parameter bit ROM_PROTECT = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] GS_ADDR,
    input  logic [7:0]        GS_DI,
    output logic [7:0]        GS_DO,
    input  logic              GS_RD,
    input  logic              GS_WR,
    output logic              GS_WAIT,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [7:0]        LD_DI,
    input  logic              LD_WR,
    output logic              LD_BUSY,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [7:0]        SRAM_DQ_O,
    input  logic [7:0]        SRAM_DQ_I,
    output logic              SRAM_OE,
    output logic              SRAM_WE
);
    localparam int CW = cnt_w(ACC_CYCLES);

    state_e            state_q;
    owner_e            owner_q, last_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] sram_addr_q, gs_addr_l_q, ld_addr;
    logic [7:0]        sram_dq_q, gs_do_q, ld_data;
    logic              oe_q, we_q, gs_done_q, gs_rd_l_q, ld_busy;
    logic              gs_req, gs_clr, grant_ld, rom_page, acc_end;

    gs_ld_slot u_slot (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .wr_i   (LD_WR),
        .addr_i (LD_ADDR),
        .data_i (LD_DI),
        .clr_i  (acc_end && owner_q == OWN_LD),
        .busy_o (ld_busy),
        .addr_o (ld_addr),
        .data_o (ld_data)
    );

    assign gs_req   = (GS_RD | GS_WR) & ~gs_done_q;
    assign gs_clr   = ~(GS_RD | GS_WR) | (GS_ADDR != gs_addr_l_q) | (GS_RD != gs_rd_l_q);
    // A pending loader yields to GS only when the loader held the previous grant
    assign grant_ld = ld_busy & (~gs_req | (last_q == OWN_GS));
    assign rom_page = ROM_PROTECT && (GS_ADDR[ADDR_W-1:15] == '0);
    assign acc_end  = (state_q == ACCESS) && (cnt_q == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            owner_q     <= OWN_GS;
            last_q      <= OWN_GS;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            gs_do_q     <= '0;
            gs_done_q   <= 1'b0;
            gs_addr_l_q <= '0;
            gs_rd_l_q   <= 1'b0;
        end else begin
            if (gs_done_q && gs_clr)
                gs_done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (gs_req || ld_busy) begin
                    state_q     <= ACCESS;
                    cnt_q       <= CW'(ACC_CYCLES - 1);
                    owner_q     <= grant_ld ? OWN_LD : OWN_GS;
                    sram_addr_q <= grant_ld ? ld_addr : GS_ADDR;
                    sram_dq_q   <= grant_ld ? ld_data : GS_DI;
                    oe_q        <= ~grant_ld & GS_RD;
                    we_q        <= grant_ld | (~GS_RD & ~rom_page);
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                state_q <= IDLE;
                oe_q    <= 1'b0;
                we_q    <= 1'b0;
                last_q  <= owner_q;
                if (owner_q == OWN_GS) begin
                    gs_done_q   <= 1'b1;
                    gs_addr_l_q <= sram_addr_q;
                    gs_rd_l_q   <= oe_q;
                    if (oe_q)
                        gs_do_q <= SRAM_DQ_I;
                end
            end
        end
    end

    assign GS_WAIT   = gs_req;
    assign GS_DO     = gs_do_q;
    assign LD_BUSY   = ld_busy;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ_O = sram_dq_q;
    assign SRAM_OE   = oe_q;
    assign SRAM_WE   = we_q;
endmodule

// File: tb/tb_gs_mem_arbiter.sv
// tb_gs_mem_arbiter: vector table, corner sequences and randomized round-robin model for gs_mem_arbiter
module tb_gs_mem_arbiter;
    import gs_mem_pkg::*;

    localparam int A = 2;

    typedef struct {
        logic        we;
        logic [20:0] a;
        logic [7:0]  d;
        int          gap;
    } acc_t;

    typedef struct {
        logic        rd;
        logic [20:0] a;
        logic [7:0]  d;
        int          hold;
        int          span;
        int          nacc;
        logic [7:0]  gdo;
    } vec_t;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic [20:0] GS_ADDR = '0, LD_ADDR = '0, SRAM_ADDR;
    logic [7:0]  GS_DI = '0, LD_DI = '0, GS_DO, SRAM_DQ_O, SRAM_DQ_I;
    logic        GS_RD = 1'b0, GS_WR = 1'b0, LD_WR = 1'b0;
    logic        GS_WAIT, LD_BUSY, SRAM_OE, SRAM_WE;

    int   checks = 0, failures = 0;
    acc_t mon_q[$], exp_q[$];
    logic prev_act = 1'b0, abort = 1'b0;
    int   width = 0, idle_n = 100;

    gs_mem_arbiter #(.ACC_CYCLES(A), .ROM_PROTECT(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .GS_ADDR(GS_ADDR), .GS_DI(GS_DI), .GS_DO(GS_DO), .GS_RD(GS_RD), .GS_WR(GS_WR), .GS_WAIT(GS_WAIT),
        .LD_ADDR(LD_ADDR), .LD_DI(LD_DI), .LD_WR(LD_WR), .LD_BUSY(LD_BUSY),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_I(SRAM_DQ_I), .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] sram_fn(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'hF8;
    endfunction

    assign SRAM_DQ_I = SRAM_OE ? sram_fn(SRAM_ADDR) : 8'h00;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gs_op(input logic rd, input logic [20:0] a, input logic [7:0] d, output int span);
        GS_ADDR = a;
        GS_DI   = d;
        GS_RD   = rd;
        GS_WR   = ~rd;
        span    = 0;
        tick();
        while (GS_WAIT && span < 100) begin
            span++;
            tick();
        end
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_we"}, 32'(mon_q[i].we), 32'(exp_q[i].we));
            chk({tag, "_addr"}, 32'(mon_q[i].a), 32'(exp_q[i].a));
            if (exp_q[i].we)
                chk({tag, "_data"}, 32'(mon_q[i].d), 32'(exp_q[i].d));
        end
    endtask

    // Strobe monitor: logs each SRAM access and checks its width away from the clock edge
    always @(negedge CLK) begin
        if (RESET && (SRAM_OE || SRAM_WE))
            abort = 1'b1;
        if (SRAM_OE || SRAM_WE) begin
            if (!prev_act) begin
                mon_q.push_back('{SRAM_WE, SRAM_ADDR, SRAM_DQ_O, idle_n});
                width = 0;
            end
            chk("oe_we_exclusive", 32'(SRAM_OE & SRAM_WE), 32'd0);
            width++;
            idle_n = 0;
        end else begin
            if (prev_act && !abort)
                chk("strobe_width", 32'(width), 32'(A));
            if (prev_act)
                abort = 1'b0;
            idle_n++;
        end
        prev_act = SRAM_OE || SRAM_WE;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[6];
        int          span, n, mode;
        logic        rd, ld_first;
        logic [20:0] ga, la;
        logic [7:0]  gd, ldd, gdo_m;
        owner_e      last_m;

        tv[0] = '{1'b1, 21'h08123, 8'h00, 4, A, 1, 8'h5A};
        tv[1] = '{1'b0, 21'h00100, 8'h33, 2, A, 0, 8'h5A};
        tv[2] = '{1'b0, 21'h08100, 8'h33, 2, A, 1, 8'h5A};
        tv[3] = '{1'b1, 21'h1F0F0, 8'h00, 2, A, 1, sram_fn(21'h1F0F0)};
        tv[4] = '{1'b1, 21'h00007, 8'h00, 1, A, 1, sram_fn(21'h00007)};
        tv[5] = '{1'b0, 21'h1FFFFF, 8'hA5, 1, A, 1, sram_fn(21'h00007)};

        tick();
        tick();
        chk("rst_oe", 32'(SRAM_OE), 32'd0);
        chk("rst_we", 32'(SRAM_WE), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_dq", 32'(SRAM_DQ_O), 32'd0);
        chk("rst_gs_do", 32'(GS_DO), 32'd0);
        chk("rst_ld_busy", 32'(LD_BUSY), 32'd0);
        chk("rst_wait", 32'(GS_WAIT), 32'd0);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            mon_q.delete();
            gs_op(tv[i].rd, tv[i].a, tv[i].d, span);
            chk($sformatf("vec%0d_span", i), 32'(span), 32'(tv[i].span));
            repeat (tv[i].hold) begin
                tick();
                chk($sformatf("vec%0d_wait_hold", i), 32'(GS_WAIT), 32'd0);
            end
            GS_RD = 1'b0;
            GS_WR = 1'b0;
            tick();
            tick();
            chk($sformatf("vec%0d_accesses", i), 32'(mon_q.size()), 32'(tv[i].nacc));
            if (mon_q.size() > 0) begin
                chk($sformatf("vec%0d_addr", i), 32'(mon_q[0].a), 32'(tv[i].a));
                chk($sformatf("vec%0d_we", i), 32'(mon_q[0].we), 32'(!tv[i].rd));
                if (!tv[i].rd)
                    chk($sformatf("vec%0d_data", i), 32'(mon_q[0].d), 32'(tv[i].d));
            end
            chk($sformatf("vec%0d_gs_do", i), 32'(GS_DO), 32'(tv[i].gdo));
            chk($sformatf("vec%0d_wait_low", i), 32'(GS_WAIT), 32'd0);
        end

        // Loader: second pulse arrives while busy and must be dropped
        mon_q.delete();
        exp_q.delete();
        LD_ADDR = 21'h00000;
        LD_DI   = 8'h11;
        LD_WR   = 1'b1;
        tick();
        LD_ADDR = 21'h00001;
        LD_DI   = 8'h22;
        n = 0;
        while (LD_BUSY && n < 50) begin
            n++;
            tick();
            LD_WR = 1'b0;
        end
        LD_WR = 1'b0;
        repeat (4) tick();
        chk("ld_busy_cycles", 32'(n), 32'd3);
        exp_q.push_back('{1'b1, 21'h00000, 8'h11, 0});
        cmp_q("ld_drop");

        // Both requests pending at the same grant edge with last_grant=GS: loader goes first
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        mon_q.delete();
        exp_q.delete();
        LD_ADDR = 21'h00ABC;
        LD_DI   = 8'h77;
        LD_WR   = 1'b1;
        tick();
        LD_WR = 1'b0;
        gs_op(1'b1, 21'h08055, 8'h00, span);
        chk("contend_span", 32'(span), 32'(2 * A + 1));
        chk("contend_gs_do", 32'(GS_DO), 32'(sram_fn(21'h08055)));
        GS_RD = 1'b0;
        repeat (3) tick();
        exp_q.push_back('{1'b1, 21'h00ABC, 8'h77, 0});
        exp_q.push_back('{1'b0, 21'h08055, 8'h00, 0});
        cmp_q("contend");
        if (mon_q.size() == 2)
            chk("contend_turnaround", 32'(mon_q[1].gap), 32'd1);

        // Back-to-back reads, address change only
        mon_q.delete();
        exp_q.delete();
        gs_op(1'b1, 21'h08000, 8'h00, span);
        chk("b2b_span0", 32'(span), 32'(A));
        chk("b2b_do0", 32'(GS_DO), 32'(sram_fn(21'h08000)));
        gs_op(1'b1, 21'h08001, 8'h00, span);
        chk("b2b_span1", 32'(span), 32'(A + 1));
        chk("b2b_do1", 32'(GS_DO), 32'(sram_fn(21'h08001)));
        GS_RD = 1'b0;
        repeat (3) tick();
        exp_q.push_back('{1'b0, 21'h08000, 8'h00, 0});
        exp_q.push_back('{1'b0, 21'h08001, 8'h00, 0});
        cmp_q("b2b");

        // Address changes while the access is in flight
        mon_q.delete();
        exp_q.delete();
        GS_ADDR = 21'h08200;
        GS_RD   = 1'b1;
        tick();
        GS_ADDR = 21'h08300;
        tick();
        tick();
        chk("amove_do0", 32'(GS_DO), 32'(sram_fn(21'h08200)));
        chk("amove_wait_gap", 32'(GS_WAIT), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (GS_WAIT && n < 20);
        chk("amove_span", 32'(n), 32'(A + 2));
        chk("amove_do1", 32'(GS_DO), 32'(sram_fn(21'h08300)));
        GS_RD = 1'b0;
        repeat (3) tick();
        exp_q.push_back('{1'b0, 21'h08200, 8'h00, 0});
        exp_q.push_back('{1'b0, 21'h08300, 8'h00, 0});
        cmp_q("amove");

        // Strobe drops while the access is in flight
        mon_q.delete();
        exp_q.delete();
        GS_ADDR = 21'h08400;
        GS_RD   = 1'b1;
        tick();
        GS_RD = 1'b0;
        tick();
        tick();
        chk("sdrop_do", 32'(GS_DO), 32'(sram_fn(21'h08400)));
        tick();
        gs_op(1'b1, 21'h08400, 8'h00, span);
        chk("sdrop_reissue_span", 32'(span), 32'(A));
        GS_RD = 1'b0;
        repeat (3) tick();
        exp_q.push_back('{1'b0, 21'h08400, 8'h00, 0});
        exp_q.push_back('{1'b0, 21'h08400, 8'h00, 0});
        cmp_q("sdrop");

        // Reset in the middle of a loader write
        LD_ADDR = 21'h00200;
        LD_DI   = 8'h44;
        LD_WR   = 1'b1;
        tick();
        LD_WR = 1'b0;
        tick();
        chk("mid_we_active", 32'(SRAM_WE), 32'd1);
        RESET = 1'b1;
        tick();
        chk("mid_rst_we", 32'(SRAM_WE), 32'd0);
        chk("mid_rst_oe", 32'(SRAM_OE), 32'd0);
        chk("mid_rst_busy", 32'(LD_BUSY), 32'd0);
        chk("mid_rst_do", 32'(GS_DO), 32'd0);
        chk("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
        RESET = 1'b0;
        tick();
        mon_q.delete();
        exp_q.delete();
        gs_op(1'b1, 21'h08123, 8'h00, span);
        chk("post_rst_span", 32'(span), 32'(A));
        chk("post_rst_do", 32'(GS_DO), 32'h5A);
        GS_RD = 1'b0;
        repeat (3) tick();
        exp_q.push_back('{1'b0, 21'h08123, 8'h00, 0});
        cmp_q("post_rst");

        // Randomized traffic against a round-robin reference model
        last_m = OWN_GS;
        gdo_m  = 8'h5A;
        for (int it = 0; it < 80; it++) begin
            mode = int'($urandom_range(0, 2));
            rd   = 1'($urandom_range(0, 1));
            ga   = 21'($urandom_range(0, 32'h1FFFFF));
            if ($urandom_range(0, 3) == 0)
                ga[20:15] = 6'd0;
            gd  = 8'($urandom_range(0, 255));
            la  = 21'($urandom_range(0, 32'h1FFFFF));
            ldd = 8'($urandom_range(0, 255));
            mon_q.delete();
            exp_q.delete();
            if (mode == 1) begin
                LD_ADDR = la;
                LD_DI   = ldd;
                LD_WR   = 1'b1;
                tick();
                LD_WR = 1'b0;
                exp_q.push_back('{1'b1, la, ldd, 0});
                last_m = OWN_LD;
                repeat (6) tick();
                chk("rnd_ld_idle", 32'(LD_BUSY), 32'd0);
            end else begin
                if (mode == 2) begin
                    LD_ADDR = la;
                    LD_DI   = ldd;
                    LD_WR   = 1'b1;
                    tick();
                    LD_WR = 1'b0;
                end
                ld_first = (mode == 2) && (last_m == OWN_GS);
                if (ld_first)
                    exp_q.push_back('{1'b1, la, ldd, 0});
                if (rd || ga[20:15] != 6'd0)
                    exp_q.push_back('{!rd, ga, gd, 0});
                if (mode == 2 && !ld_first)
                    exp_q.push_back('{1'b1, la, ldd, 0});
                gs_op(rd, ga, gd, span);
                chk("rnd_span", 32'(span), ld_first ? 32'(2 * A + 1) : 32'(A));
                if (rd)
                    gdo_m = sram_fn(ga);
                chk("rnd_gs_do", 32'(GS_DO), 32'(gdo_m));
                GS_RD = 1'b0;
                GS_WR = 1'b0;
                repeat (8) tick();
                last_m = (mode == 2 && !ld_first) ? OWN_LD : OWN_GS;
            end
            cmp_q("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
